// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_prog #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int FWFT   = 0
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH+1)-1:0]   almst_e_lvl,
  input  logic [$clog2(DEPTH+1)-1:0]   almst_f_lvl,
  input  logic                         err_clr,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_valid,
  output logic [$clog2(DEPTH+1)-1:0]   data_count,
  output logic                         empty,
  output logic                         full,
  output logic                         almst_empty,
  output logic                         almst_full,
  output logic                         ovf,
  output logic                         udf
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              wr_acc, rd_acc;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + CNT_W'(1);
    else if (!wr_acc && rd_acc)
      count_nxt = count - CNT_W'(1);
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_acc)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_FULL);
    end
  end

  // A new offending request in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full)
        ovf <= 1'b1;
      else if (err_clr)
        ovf <= 1'b0;
      if (rd_en && empty)
        udf <= 1'b1;
      else if (err_clr)
        udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out   = empty ? '0 : mem[rd_ptr];
      assign data_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              dv_q;

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
          dv_q   <= 1'b1;
        end else begin
          dv_q   <= 1'b0;
        end
      end

      assign data_out   = dout_q;
      assign data_valid = dv_q;
    end
  endgenerate

  assign data_count  = count;
  assign almst_empty = (count <= almst_e_lvl);
  assign almst_full  = (count >= almst_f_lvl);

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: a DEPTH=5 standard-read instance checked by table and a
// queue-based model, and a DEPTH=32 FWFT instance for thresholds and async reset.
module tb_fifo_sync_prog;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_wr, a_rd, a_clr;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_ael, a_afl, a_cnt;
  logic       a_dv, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;

  logic       b_wr, b_rd, b_clr;
  logic [7:0] b_din, b_dout;
  logic [5:0] b_ael, b_afl, b_cnt;
  logic       b_dv, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;

  fifo_sync_prog #(.DATA_W(8), .DEPTH(5), .FWFT(0)) dut_a (
    .clk(clk), .n_reset(n_reset), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
    .almst_e_lvl(a_ael), .almst_f_lvl(a_afl), .err_clr(a_clr),
    .data_out(a_dout), .data_valid(a_dv), .data_count(a_cnt), .empty(a_empty),
    .full(a_full), .almst_empty(a_ae), .almst_full(a_af), .ovf(a_ovf), .udf(a_udf)
  );

  fifo_sync_prog #(.DATA_W(8), .DEPTH(32), .FWFT(1)) dut_b (
    .clk(clk), .n_reset(n_reset), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
    .almst_e_lvl(b_ael), .almst_f_lvl(b_afl), .err_clr(b_clr),
    .data_out(b_dout), .data_valid(b_dv), .data_count(b_cnt), .empty(b_empty),
    .full(b_full), .almst_empty(b_ae), .almst_full(b_af), .ovf(b_ovf), .udf(b_udf)
  );

  int passes = 0;
  int total  = 0;

  // Reference model for dut_a: contents as a queue plus the registered read outputs.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_dv, m_ovf, m_udf;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       e;
    logic       f;
    logic [7:0] dout;
    logic       dv;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl[17];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic reset_all();
    a_wr = 0; a_rd = 0; a_clr = 0; a_din = 0;
    b_wr = 0; b_rd = 0; b_clr = 0; b_din = 0;
    n_reset = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    mq.delete();
    m_dout = 8'h00; m_dv = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic apply_cycle_a(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
    int  sz;
    bit  wacc, racc;
    a_wr = wr; a_din = din; a_rd = rd; a_clr = clr;
    sz   = mq.size();
    wacc = wr && (sz < 5);
    racc = rd && (sz > 0);
    if (racc) begin
      m_dout = mq.pop_front();
      m_dv   = 1'b1;
    end else begin
      m_dv   = 1'b0;
    end
    if (wacc) mq.push_back(din);
    if (wr && !wacc) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !racc) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    @(posedge clk); #1;
    check_output("a_cnt",   64'(a_cnt),   64'(mq.size()));
    check_output("a_empty", 64'(a_empty), 64'(mq.size() == 0));
    check_output("a_full",  64'(a_full),  64'(mq.size() == 5));
    check_output("a_dout",  64'(a_dout),  64'(m_dout));
    check_output("a_dv",    64'(a_dv),    64'(m_dv));
    check_output("a_ovf",   64'(a_ovf),   64'(m_ovf));
    check_output("a_udf",   64'(a_udf),   64'(m_udf));
    check_output("a_ae",    64'(a_ae),    64'(mq.size() <= int'(a_ael)));
    check_output("a_af",    64'(a_af),    64'(mq.size() >= int'(a_afl)));
  endtask

  task automatic write_b(input logic [7:0] din);
    b_wr = 1'b1; b_din = din; b_rd = 1'b0;
    @(posedge clk); #1;
    b_wr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    a_ael = 3'd1; a_afl = 3'd4;
    b_ael = 6'd3; b_afl = 6'd28;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h15, 1'b0, 1'b0, 5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h16, 1'b0, 1'b0, 5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'h13, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h14, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h15, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h21, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0};

    reset_all();
    check_output("rst_a_cnt",   64'(a_cnt),   64'd0);
    check_output("rst_a_empty", 64'(a_empty), 64'd1);
    check_output("rst_a_full",  64'(a_full),  64'd0);
    check_output("rst_a_dout",  64'(a_dout),  64'd0);
    check_output("rst_a_dv",    64'(a_dv),    64'd0);
    check_output("rst_a_flags", 64'({a_ovf, a_udf}), 64'd0);
    check_output("rst_a_ae",    64'(a_ae),    64'd1);
    check_output("rst_b_dv",    64'(b_dv),    64'd0);
    check_output("rst_b_dout",  64'(b_dout),  64'd0);
    check_output("rst_b_af",    64'(b_af),    64'd0);
    b_afl = 6'd0; #1;
    check_output("rst_b_af_lvl0", 64'(b_af), 64'd1);
    b_afl = 6'd28; #1;

    for (int i = 0; i < 17; i++) begin
      a_wr = tbl[i].wr; a_din = tbl[i].din; a_rd = tbl[i].rd; a_clr = tbl[i].clr;
      @(posedge clk); #1;
      check_output($sformatf("tbl%0d_cnt", i),  64'(a_cnt),   64'(tbl[i].cnt));
      check_output($sformatf("tbl%0d_e", i),    64'(a_empty), 64'(tbl[i].e));
      check_output($sformatf("tbl%0d_f", i),    64'(a_full),  64'(tbl[i].f));
      check_output($sformatf("tbl%0d_dout", i), 64'(a_dout),  64'(tbl[i].dout));
      check_output($sformatf("tbl%0d_dv", i),   64'(a_dv),    64'(tbl[i].dv));
      check_output($sformatf("tbl%0d_ovf", i),  64'(a_ovf),   64'(tbl[i].ovf));
      check_output($sformatf("tbl%0d_udf", i),  64'(a_udf),   64'(tbl[i].udf));
    end

    // Pointer wrap: hold two words and stream 12 simultaneous write/read pairs.
    reset_all();
    apply_cycle_a(1'b1, 8'h30, 1'b0, 1'b0);
    apply_cycle_a(1'b1, 8'h31, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      apply_cycle_a(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      check_output("wrap_cnt", 64'(a_cnt), 64'd2);
    end

    // Randomised traffic with alternating fill-biased and drain-biased phases.
    for (int k = 0; k < 400; k++) begin
      int  bias;
      logic wr, rd;
      bias = ((k / 40) % 2 == 0) ? 3 : 1;
      wr = (int'($urandom_range(0, 3)) < bias);
      rd = (int'($urandom_range(0, 3)) < 4 - bias);
      a_ael = 3'($urandom_range(0, 5));
      a_afl = 3'($urandom_range(0, 5));
      apply_cycle_a(wr, 8'($urandom), rd, ($urandom_range(0, 7) == 0));
    end
    a_wr = 0; a_rd = 0; a_clr = 0;

    // FWFT: written word appears the cycle after the write edge.
    reset_all();
    write_b(8'hA5);
    check_output("fwft_dout", 64'(b_dout), 64'hA5);
    check_output("fwft_dv",   64'(b_dv),   64'd1);
    b_rd = 1'b1;
    @(posedge clk); #1;
    b_rd = 1'b0;
    check_output("fwft_pop_empty", 64'(b_empty), 64'd1);
    check_output("fwft_pop_dv",    64'(b_dv),    64'd0);

    for (int i = 1; i <= 28; i++) begin
      write_b(8'(i));
      check_output("fill_cnt", 64'(b_cnt), 64'(i));
      check_output("fill_af",  64'(b_af),  64'(i >= 28));
      check_output("fill_ae",  64'(b_ae),  64'(i <= 3));
    end
    check_output("fill_head", 64'(b_dout), 64'h01);
    b_afl = 6'd30; #1;
    check_output("lvl_change_af", 64'(b_af), 64'd0);
    write_b(8'd29);
    write_b(8'd30);
    check_output("af_at_30", 64'(b_af), 64'd1);
    b_rd = 1'b1;
    @(posedge clk); #1;
    b_rd = 1'b0;
    check_output("fwft_next_word", 64'(b_dout), 64'h02);

    // Asynchronous reset between clock edges with seven words stored.
    reset_all();
    for (int i = 0; i < 7; i++) write_b(8'(8'h50 + i));
    check_output("pre_rst_cnt", 64'(b_cnt), 64'd7);
    #2;
    n_reset = 1'b0;
    #1;
    check_output("arst_cnt",   64'(b_cnt),   64'd0);
    check_output("arst_empty", 64'(b_empty), 64'd1);
    check_output("arst_full",  64'(b_full),  64'd0);
    check_output("arst_dv",    64'(b_dv),    64'd0);
    check_output("arst_dout",  64'(b_dout),  64'd0);
    check_output("arst_flags", 64'({b_ovf, b_udf}), 64'd0);
    check_output("arst_ae",    64'(b_ae),    64'd1);
    #1;
    n_reset = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
